// File: rtl/sodor_mem_arbiter.sv
// sodor_mem_arbiter
// Two-requester arbiter (instruction fetch and data port) in front of a
// single shared memory request router. At most one request is outstanding;
// the response is steered back to the requester that owns it. A WAIT-state
// watchdog aborts a request that never gets a response.
//
// Ports
//   clock / reset                 : clock, asynchronous active-low reset
//   io_imem_req_*                 : fetch request (valid, addr) and ready
//   io_imem_resp_*                : fetch response (valid, data)
//   io_dmem_req_*                 : data request (valid, addr, data, fcn, typ) and ready
//   io_dmem_resp_*                : data response (valid, data)
//   io_mem_req_*                  : shared request toward the router
//   io_mem_resp_*                 : shared response from the router
//   io_respAddress                : registered address of the outstanding request
//   io_busy                       : high while a request is outstanding
//   io_timeout                    : one-cycle pulse when the watchdog aborts
module sodor_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_imem_req_valid,
  input  logic [31:0] io_imem_req_bits_addr,
  output logic        io_imem_req_ready,
  output logic        io_imem_resp_valid,
  output logic [31:0] io_imem_resp_bits_data,
  input  logic        io_dmem_req_valid,
  input  logic [31:0] io_dmem_req_bits_addr,
  input  logic [31:0] io_dmem_req_bits_data,
  input  logic        io_dmem_req_bits_fcn,
  input  logic [2:0]  io_dmem_req_bits_typ,
  output logic        io_dmem_req_ready,
  output logic        io_dmem_resp_valid,
  output logic [31:0] io_dmem_resp_bits_data,
  output logic        io_mem_req_valid,
  output logic [31:0] io_mem_req_bits_addr,
  output logic [31:0] io_mem_req_bits_data,
  output logic        io_mem_req_bits_fcn,
  output logic [2:0]  io_mem_req_bits_typ,
  input  logic        io_mem_resp_valid,
  input  logic [31:0] io_mem_resp_bits_data,
  output logic [31:0] io_respAddress,
  output logic        io_busy,
  output logic        io_timeout
);

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_e;
  typedef enum logic {SRC_IMEM = 1'b0, SRC_DMEM = 1'b1} src_e;

  // Last WAIT-cycle count value before the watchdog fires.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  src_e        owner_q, owner_d;
  src_e        last_grant_q, last_grant_d;
  logic [31:0] resp_addr_q, resp_addr_d;
  logic [15:0] cnt_q, cnt_d;

  src_e        winner_s;
  logic        grant_s;

  // State and bookkeeping registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= SRC_IMEM;
      last_grant_q <= SRC_IMEM;
      resp_addr_q  <= 32'd0;
      cnt_q        <= 16'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      resp_addr_q  <= resp_addr_d;
      cnt_q        <= cnt_d;
    end
  end

  // Arbitration, request muxing, response steering and next-state logic.
  always_comb begin
    state_d                = state_q;
    owner_d                = owner_q;
    last_grant_d           = last_grant_q;
    resp_addr_d            = resp_addr_q;
    cnt_d                  = cnt_q;
    winner_s               = SRC_IMEM;
    grant_s                = 1'b0;
    io_imem_req_ready      = 1'b0;
    io_dmem_req_ready      = 1'b0;
    io_imem_resp_valid     = 1'b0;
    io_imem_resp_bits_data = 32'd0;
    io_dmem_resp_valid     = 1'b0;
    io_dmem_resp_bits_data = 32'd0;
    io_mem_req_valid       = 1'b0;
    io_mem_req_bits_addr   = 32'd0;
    io_mem_req_bits_data   = 32'd0;
    io_mem_req_bits_fcn    = 1'b0;
    io_mem_req_bits_typ    = 3'd0;
    io_busy                = 1'b0;
    io_timeout             = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Round-robin on contention: the side not granted last time wins.
        if (io_imem_req_valid && io_dmem_req_valid) begin
          winner_s = (last_grant_q == SRC_IMEM) ? SRC_DMEM : SRC_IMEM;
        end else if (io_dmem_req_valid) begin
          winner_s = SRC_DMEM;
        end else begin
          winner_s = SRC_IMEM;
        end
        // Reset gating keeps every request-side output low while reset is held.
        grant_s = reset && (io_imem_req_valid || io_dmem_req_valid);

        if (grant_s) begin
          io_mem_req_valid = 1'b1;
          if (winner_s == SRC_DMEM) begin
            io_dmem_req_ready    = 1'b1;
            io_mem_req_bits_addr = io_dmem_req_bits_addr;
            io_mem_req_bits_data = io_dmem_req_bits_data;
            io_mem_req_bits_fcn  = io_dmem_req_bits_fcn;
            io_mem_req_bits_typ  = io_dmem_req_bits_typ;
          end else begin
            // Fetches are always word reads.
            io_imem_req_ready    = 1'b1;
            io_mem_req_bits_addr = io_imem_req_bits_addr;
            io_mem_req_bits_data = 32'd0;
            io_mem_req_bits_fcn  = 1'b0;
            io_mem_req_bits_typ  = 3'd3;
          end
          state_d      = ST_WAIT;
          owner_d      = winner_s;
          last_grant_d = winner_s;
          resp_addr_d  = io_mem_req_bits_addr;
          cnt_d        = 16'd0;
        end else begin
          // Stray responses in IDLE are dropped: outputs stay at defaults.
          state_d = ST_IDLE;
        end
      end

      ST_WAIT: begin
        io_busy = 1'b1;
        cnt_d   = cnt_q + 16'd1;
        // A response wins over the watchdog firing in the same cycle.
        if (io_mem_resp_valid) begin
          if (owner_q == SRC_DMEM) begin
            io_dmem_resp_valid     = 1'b1;
            io_dmem_resp_bits_data = io_mem_resp_bits_data;
          end else begin
            io_imem_resp_valid     = 1'b1;
            io_imem_resp_bits_data = io_mem_resp_bits_data;
          end
          state_d = ST_IDLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          io_timeout = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign io_respAddress = resp_addr_q;

endmodule

// File: tb/tb_sodor_mem_arbiter.sv
// Self-checking bench for sodor_mem_arbiter (TIMEOUT_CYCLES = 4).
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge. Granted requests push their expected response owner and
// data into a scoreboard queue that is popped when the response cycle is
// checked.
module tb_sodor_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_imem_req_valid;
  logic [31:0] io_imem_req_bits_addr;
  logic        io_imem_req_ready;
  logic        io_imem_resp_valid;
  logic [31:0] io_imem_resp_bits_data;
  logic        io_dmem_req_valid;
  logic [31:0] io_dmem_req_bits_addr;
  logic [31:0] io_dmem_req_bits_data;
  logic        io_dmem_req_bits_fcn;
  logic [2:0]  io_dmem_req_bits_typ;
  logic        io_dmem_req_ready;
  logic        io_dmem_resp_valid;
  logic [31:0] io_dmem_resp_bits_data;
  logic        io_mem_req_valid;
  logic [31:0] io_mem_req_bits_addr;
  logic [31:0] io_mem_req_bits_data;
  logic        io_mem_req_bits_fcn;
  logic [2:0]  io_mem_req_bits_typ;
  logic        io_mem_resp_valid;
  logic [31:0] io_mem_resp_bits_data;
  logic [31:0] io_respAddress;
  logic        io_busy;
  logic        io_timeout;

  sodor_mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .io_imem_req_valid      (io_imem_req_valid),
    .io_imem_req_bits_addr  (io_imem_req_bits_addr),
    .io_imem_req_ready      (io_imem_req_ready),
    .io_imem_resp_valid     (io_imem_resp_valid),
    .io_imem_resp_bits_data (io_imem_resp_bits_data),
    .io_dmem_req_valid      (io_dmem_req_valid),
    .io_dmem_req_bits_addr  (io_dmem_req_bits_addr),
    .io_dmem_req_bits_data  (io_dmem_req_bits_data),
    .io_dmem_req_bits_fcn   (io_dmem_req_bits_fcn),
    .io_dmem_req_bits_typ   (io_dmem_req_bits_typ),
    .io_dmem_req_ready      (io_dmem_req_ready),
    .io_dmem_resp_valid     (io_dmem_resp_valid),
    .io_dmem_resp_bits_data (io_dmem_resp_bits_data),
    .io_mem_req_valid       (io_mem_req_valid),
    .io_mem_req_bits_addr   (io_mem_req_bits_addr),
    .io_mem_req_bits_data   (io_mem_req_bits_data),
    .io_mem_req_bits_fcn    (io_mem_req_bits_fcn),
    .io_mem_req_bits_typ    (io_mem_req_bits_typ),
    .io_mem_resp_valid      (io_mem_resp_valid),
    .io_mem_resp_bits_data  (io_mem_resp_bits_data),
    .io_respAddress         (io_respAddress),
    .io_busy                (io_busy),
    .io_timeout             (io_timeout)
  );

  always #5 clock = ~clock;

  int checks_total  = 0;
  int checks_passed = 0;

  typedef struct {
    logic        is_dmem;
    logic [31:0] data;
  } exp_resp_t;

  exp_resp_t sb_q[$];

  typedef struct {
    logic        iv;
    logic [31:0] ia;
    logic        dv;
    logic [31:0] da;
    logic [31:0] dd;
    logic        df;
    logic [2:0]  dt;
    logic        exp_dmem;
    logic [31:0] rdata;
    int          delay;
  } vec_t;

  vec_t vecs[6];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got %b, want %b", name, act, exp);
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic settle;
    @(negedge clock);
  endtask

  task automatic clear_reqs;
    io_imem_req_valid     = 1'b0;
    io_imem_req_bits_addr = 32'd0;
    io_dmem_req_valid     = 1'b0;
    io_dmem_req_bits_addr = 32'd0;
    io_dmem_req_bits_data = 32'd0;
    io_dmem_req_bits_fcn  = 1'b0;
    io_dmem_req_bits_typ  = 3'd0;
  endtask

  // Pop the scoreboard and compare the response-cycle outputs against it.
  task automatic check_resp(input string tag);
    exp_resp_t e;
    if (sb_q.size() == 0) begin
      checks_total++;
      $display("FAIL %s_sb_empty: got empty scoreboard, want one entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk1 ({tag, "_imem_rv"}, io_imem_resp_valid, !e.is_dmem);
      chk32({tag, "_imem_rd"}, io_imem_resp_bits_data, e.is_dmem ? 32'd0 : e.data);
      chk1 ({tag, "_dmem_rv"}, io_dmem_resp_valid, e.is_dmem);
      chk32({tag, "_dmem_rd"}, io_dmem_resp_bits_data, e.is_dmem ? e.data : 32'd0);
      chk1 ({tag, "_timeout"}, io_timeout, 1'b0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk1 ({tag, "_mreq_v"}, io_mem_req_valid, 1'b0);
    chk1 ({tag, "_irdy"}, io_imem_req_ready, 1'b0);
    chk1 ({tag, "_drdy"}, io_dmem_req_ready, 1'b0);
    chk1 ({tag, "_irv"}, io_imem_resp_valid, 1'b0);
    chk1 ({tag, "_drv"}, io_dmem_resp_valid, 1'b0);
    chk1 ({tag, "_busy"}, io_busy, 1'b0);
    chk1 ({tag, "_tmo"}, io_timeout, 1'b0);
    chk32({tag, "_raddr"}, io_respAddress, 32'd0);
  endtask

  task automatic do_reset;
    tick;
    reset = 1'b0;
    clear_reqs;
    io_mem_resp_valid     = 1'b0;
    io_mem_resp_bits_data = 32'd0;
    tick;
    reset = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_resp_t   e;
    logic [31:0] ea;
    logic [31:0] ed;
    logic        ef;
    logic [2:0]  et;
    string       t;
    t  = $sformatf("v%0d", idx);
    ea = v.exp_dmem ? v.da : v.ia;
    ed = v.exp_dmem ? v.dd : 32'd0;
    ef = v.exp_dmem ? v.df : 1'b0;
    et = v.exp_dmem ? v.dt : 3'd3;
    tick;
    io_imem_req_valid     = v.iv;
    io_imem_req_bits_addr = v.ia;
    io_dmem_req_valid     = v.dv;
    io_dmem_req_bits_addr = v.da;
    io_dmem_req_bits_data = v.dd;
    io_dmem_req_bits_fcn  = v.df;
    io_dmem_req_bits_typ  = v.dt;
    settle;
    chk1 ({t, "_mreq_v"}, io_mem_req_valid, 1'b1);
    chk32({t, "_addr"}, io_mem_req_bits_addr, ea);
    chk32({t, "_data"}, io_mem_req_bits_data, ed);
    chk1 ({t, "_fcn"}, io_mem_req_bits_fcn, ef);
    chk32({t, "_typ"}, {29'd0, io_mem_req_bits_typ}, {29'd0, et});
    chk1 ({t, "_irdy"}, io_imem_req_ready, !v.exp_dmem);
    chk1 ({t, "_drdy"}, io_dmem_req_ready, v.exp_dmem);
    e.is_dmem = v.exp_dmem;
    e.data    = v.rdata;
    sb_q.push_back(e);
    for (int c = 1; c < v.delay; c++) begin
      tick;
      clear_reqs;
      settle;
      chk1 ({t, "_wait_busy"}, io_busy, 1'b1);
      chk32({t, "_wait_raddr"}, io_respAddress, ea);
      chk1 ({t, "_wait_mreq_v"}, io_mem_req_valid, 1'b0);
      chk1 ({t, "_wait_irv"}, io_imem_resp_valid, 1'b0);
      chk1 ({t, "_wait_drv"}, io_dmem_resp_valid, 1'b0);
    end
    tick;
    clear_reqs;
    io_mem_resp_valid     = 1'b1;
    io_mem_resp_bits_data = v.rdata;
    settle;
    chk32({t, "_resp_raddr"}, io_respAddress, ea);
    chk1 ({t, "_resp_rdy"}, io_imem_req_ready | io_dmem_req_ready, 1'b0);
    check_resp(t);
    tick;
    io_mem_resp_valid     = 1'b0;
    io_mem_resp_bits_data = 32'd0;
    settle;
    chk1 ({t, "_idle_busy"}, io_busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, want completion");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    //            iv    ia             dv    da             dd             df    dt    dmem  rdata          delay
    vecs[0] = '{1'b1, 32'h8000_0010, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 3'd0, 1'b0, 32'hDEAD_BEEF, 2};
    vecs[1] = '{1'b1, 32'h0000_0100, 1'b1, 32'h0000_1000, 32'h1234_5678, 1'b1, 3'd2, 1'b1, 32'h0000_0001, 1};
    vecs[2] = '{1'b1, 32'h0000_0104, 1'b1, 32'h0000_2000, 32'hAAAA_5555, 1'b0, 3'd2, 1'b0, 32'h0000_0002, 2};
    vecs[3] = '{1'b1, 32'h0000_0108, 1'b1, 32'h0000_3000, 32'h0000_0000, 1'b0, 3'd0, 1'b1, 32'h0000_0003, 1};
    vecs[4] = '{1'b0, 32'h0000_0000, 1'b1, 32'h0000_0004, 32'hCAFE_F00D, 1'b1, 3'd1, 1'b1, 32'h0000_0004, 2};
    vecs[5] = '{1'b1, 32'h0000_0200, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 3'd0, 1'b0, 32'h0000_0005, 1};

    // Reset state with every input active.
    reset                 = 1'b0;
    io_imem_req_valid     = 1'b1;
    io_imem_req_bits_addr = 32'h1111_1111;
    io_dmem_req_valid     = 1'b1;
    io_dmem_req_bits_addr = 32'h2222_2222;
    io_dmem_req_bits_data = 32'h3333_3333;
    io_dmem_req_bits_fcn  = 1'b1;
    io_dmem_req_bits_typ  = 3'd2;
    io_mem_resp_valid     = 1'b1;
    io_mem_resp_bits_data = 32'h4444_4444;
    settle;
    check_all_zero("rst");
    tick;
    reset = 1'b1;
    clear_reqs;
    io_mem_resp_valid     = 1'b0;
    io_mem_resp_bits_data = 32'd0;

    // Table-driven grant / response transactions.
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Continuous contention with single-cycle responses: D, I, D, I.
    do_reset;
    tick;
    io_imem_req_valid     = 1'b1;
    io_imem_req_bits_addr = 32'h0000_0500;
    io_dmem_req_valid     = 1'b1;
    io_dmem_req_bits_addr = 32'h0000_0600;
    io_dmem_req_bits_data = 32'h1111_1111;
    io_dmem_req_bits_fcn  = 1'b1;
    io_dmem_req_bits_typ  = 3'd2;
    for (int g = 0; g < 4; g++) begin
      exp_resp_t e;
      e.is_dmem = ((g % 2) == 0);
      e.data    = 32'hC0DE_0000 + 32'(g);
      settle;
      chk1 ($sformatf("cont%0d_mreq_v", g), io_mem_req_valid, 1'b1);
      chk1 ($sformatf("cont%0d_drdy", g), io_dmem_req_ready, e.is_dmem);
      chk1 ($sformatf("cont%0d_irdy", g), io_imem_req_ready, !e.is_dmem);
      chk32($sformatf("cont%0d_addr", g), io_mem_req_bits_addr,
            e.is_dmem ? 32'h0000_0600 : 32'h0000_0500);
      sb_q.push_back(e);
      tick;
      io_mem_resp_valid     = 1'b1;
      io_mem_resp_bits_data = e.data;
      settle;
      chk1 ($sformatf("cont%0d_wait_mreq_v", g), io_mem_req_valid, 1'b0);
      check_resp($sformatf("cont%0d", g));
      tick;
      io_mem_resp_valid     = 1'b0;
      io_mem_resp_bits_data = 32'd0;
    end
    clear_reqs;
    settle;
    chk1("cont_end_mreq_v", io_mem_req_valid, 1'b0);

    // Timeout with no response; late response dropped in IDLE.
    tick;
    io_imem_req_valid     = 1'b1;
    io_imem_req_bits_addr = 32'h0000_0300;
    settle;
    chk1("tmo_grant_irdy", io_imem_req_ready, 1'b1);
    for (int w = 1; w <= 4; w++) begin
      tick;
      clear_reqs;
      settle;
      chk1($sformatf("tmo_w%0d_pulse", w), io_timeout, (w == 4));
      chk1($sformatf("tmo_w%0d_busy", w), io_busy, 1'b1);
      chk1($sformatf("tmo_w%0d_irv", w), io_imem_resp_valid, 1'b0);
    end
    tick;
    settle;
    chk1("tmo_c5_busy", io_busy, 1'b0);
    chk1("tmo_c5_pulse", io_timeout, 1'b0);
    tick;
    io_mem_resp_valid     = 1'b1;
    io_mem_resp_bits_data = 32'hBAD0_BAD0;
    settle;
    chk1 ("tmo_late_irv", io_imem_resp_valid, 1'b0);
    chk32("tmo_late_ird", io_imem_resp_bits_data, 32'd0);
    chk1 ("tmo_late_drv", io_dmem_resp_valid, 1'b0);
    chk1 ("tmo_late_busy", io_busy, 1'b0);
    tick;
    io_mem_resp_valid     = 1'b0;
    io_mem_resp_bits_data = 32'd0;

    // Response coinciding with the timeout cycle is delivered, no pulse.
    io_dmem_req_valid     = 1'b1;
    io_dmem_req_bits_addr = 32'h0000_0700;
    settle;
    chk1("race_grant_drdy", io_dmem_req_ready, 1'b1);
    begin
      exp_resp_t e;
      e.is_dmem = 1'b1;
      e.data    = 32'h5A5A_5A5A;
      sb_q.push_back(e);
    end
    for (int w = 1; w <= 3; w++) begin
      tick;
      clear_reqs;
      settle;
      chk1($sformatf("race_w%0d_pulse", w), io_timeout, 1'b0);
    end
    tick;
    io_mem_resp_valid     = 1'b1;
    io_mem_resp_bits_data = 32'h5A5A_5A5A;
    settle;
    check_resp("race");
    tick;
    io_mem_resp_valid     = 1'b0;
    io_mem_resp_bits_data = 32'd0;
    settle;
    chk1("race_idle_busy", io_busy, 1'b0);

    // Reset in WAIT after a DMEM grant; response after release is dropped.
    tick;
    io_dmem_req_valid     = 1'b1;
    io_dmem_req_bits_addr = 32'h0000_0900;
    settle;
    chk1("mrst_grant_drdy", io_dmem_req_ready, 1'b1);
    tick;
    clear_reqs;
    settle;
    chk1("mrst_wait_busy", io_busy, 1'b1);
    tick;
    reset                 = 1'b0;
    io_imem_req_valid     = 1'b1;
    io_imem_req_bits_addr = 32'h0000_0A00;
    io_dmem_req_valid     = 1'b1;
    io_dmem_req_bits_addr = 32'h0000_0B00;
    settle;
    check_all_zero("mrst_c1");
    tick;
    io_mem_resp_valid     = 1'b1;
    io_mem_resp_bits_data = 32'h7777_7777;
    settle;
    check_all_zero("mrst_c2");
    tick;
    reset = 1'b1;
    clear_reqs;
    io_mem_resp_bits_data = 32'hFEED_FACE;
    settle;
    chk1 ("mrst_after_irv", io_imem_resp_valid, 1'b0);
    chk1 ("mrst_after_drv", io_dmem_resp_valid, 1'b0);
    chk32("mrst_after_drd", io_dmem_resp_bits_data, 32'd0);
    chk1 ("mrst_after_busy", io_busy, 1'b0);
    tick;
    io_mem_resp_valid     = 1'b0;
    io_mem_resp_bits_data = 32'd0;
    io_imem_req_valid     = 1'b1;
    io_imem_req_bits_addr = 32'h0000_0C00;
    io_dmem_req_valid     = 1'b1;
    io_dmem_req_bits_addr = 32'h0000_0D00;
    settle;
    chk1("mrst_first_drdy", io_dmem_req_ready, 1'b1);
    chk1("mrst_first_irdy", io_imem_req_ready, 1'b0);
    begin
      exp_resp_t e;
      e.is_dmem = 1'b1;
      e.data    = 32'h0BAD_CAFE;
      sb_q.push_back(e);
    end
    tick;
    clear_reqs;
    io_mem_resp_valid     = 1'b1;
    io_mem_resp_bits_data = 32'h0BAD_CAFE;
    settle;
    check_resp("mrst_first");
    tick;
    io_mem_resp_valid     = 1'b0;
    io_mem_resp_bits_data = 32'd0;

    // Stray response in IDLE with no requests.
    tick;
    io_mem_resp_valid     = 1'b1;
    io_mem_resp_bits_data = 32'h9999_9999;
    settle;
    chk1 ("stray_irv", io_imem_resp_valid, 1'b0);
    chk1 ("stray_drv", io_dmem_resp_valid, 1'b0);
    chk32("stray_ird", io_imem_resp_bits_data, 32'd0);
    chk1 ("stray_busy", io_busy, 1'b0);
    tick;
    io_mem_resp_valid     = 1'b0;
    io_mem_resp_bits_data = 32'd0;
    settle;
    chk1("stray_next_busy", io_busy, 1'b0);
    chk1("stray_next_mreq_v", io_mem_req_valid, 1'b0);

    chk32("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
